// File: rtl/tlb_refill_ctrl_if.sv
// rtl/tlb_refill_ctrl_if.sv - TLB miss, page-table memory and fill/fault bundle for tlb_refill_ctrl.
interface tlb_refill_ctrl_if #(
  parameter int VPN_W = 20,
  parameter int PPN_W = 8
);
  logic             itlb_miss;
  logic [VPN_W-1:0] itlb_vpn;
  logic             dtlb_miss;
  logic [VPN_W-1:0] dtlb_vpn;
  logic [31:0]      ptbr;
  logic             mem_req;
  logic [31:0]      mem_addr;
  logic             mem_gnt;
  logic             mem_rvalid;
  logic [31:0]      mem_rdata;
  logic             itlb_write;
  logic             dtlb_write;
  logic [VPN_W-1:0] tlb_logic_page;
  logic [PPN_W-1:0] tlb_physical_page;
  logic             page_fault;
  logic             fault_is_data;
  logic [1:0]       fault_cause;
  logic [VPN_W-1:0] fault_vpn;
  logic             busy;

  modport master (
    input  itlb_miss, itlb_vpn, dtlb_miss, dtlb_vpn, ptbr,
    input  mem_gnt, mem_rvalid, mem_rdata,
    output mem_req, mem_addr,
    output itlb_write, dtlb_write, tlb_logic_page, tlb_physical_page,
    output page_fault, fault_is_data, fault_cause, fault_vpn, busy
  );

  modport slave (
    output itlb_miss, itlb_vpn, dtlb_miss, dtlb_vpn, ptbr,
    output mem_gnt, mem_rvalid, mem_rdata,
    input  mem_req, mem_addr,
    input  itlb_write, dtlb_write, tlb_logic_page, tlb_physical_page,
    input  page_fault, fault_is_data, fault_cause, fault_vpn, busy
  );
endinterface

// File: rtl/tlb_refill_ctrl.sv
// rtl/tlb_refill_ctrl.sv - shared iTLB/dTLB refill walker over a linear single-level page table.
module tlb_refill_ctrl #(
  parameter int VPN_W   = 20,
  parameter int PPN_W   = 8,
  parameter int TIMEOUT = 255
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                flush,
  tlb_refill_ctrl_if.master   bus
);
  typedef enum logic [2:0] {IDLE, REQ, WAIT, FILL, FAULT, GAP} state_t;

  localparam int          PAD      = 30 - VPN_W;
  localparam logic [7:0]  TMO_LAST = 8'(TIMEOUT - 1);

  state_t             state_q, state_d;
  logic               grant, grant_data;
  logic [VPN_W-1:0]   vpn_sel;
  logic               last_grant_q, req_is_data_q, drop_q;
  logic [VPN_W-1:0]   vpn_q, page_q, f_vpn_q;
  logic [PPN_W-1:0]   ppn_q, phys_q;
  logic [7:0]         cnt_q;
  logic [1:0]         cause_q, f_cause_q;
  logic               f_data_q;
  logic [31:0]        addr_q;
  logic               kill, fill_ok, fault_ok;
  logic               unused_rdata;

  assign unused_rdata = ^bus.mem_rdata[30:PPN_W];

  always_comb begin
    state_d    = state_q;
    grant      = 1'b0;
    grant_data = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.itlb_miss || bus.dtlb_miss) begin
          grant   = 1'b1;
          state_d = REQ;
          // On a tie the side that did not win last time goes first.
          if (bus.itlb_miss && bus.dtlb_miss) grant_data = ~last_grant_q;
          else                                grant_data = bus.dtlb_miss;
        end
      end
      REQ:  if (bus.mem_gnt) state_d = WAIT;
      WAIT: begin
        if (bus.mem_rvalid)          state_d = bus.mem_rdata[31] ? FILL : FAULT;
        else if (cnt_q == TMO_LAST)  state_d = FAULT;
      end
      FILL:    state_d = GAP;
      FAULT:   state_d = GAP;
      GAP:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign vpn_sel  = grant_data ? bus.dtlb_vpn : bus.itlb_vpn;
  assign kill     = drop_q | flush;
  assign fill_ok  = (state_q == FILL)  && !kill;
  assign fault_ok = (state_q == FAULT) && !kill;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      last_grant_q  <= 1'b1;
      req_is_data_q <= 1'b0;
      drop_q        <= 1'b0;
      vpn_q         <= '0;
      ppn_q         <= '0;
      cnt_q         <= '0;
      cause_q       <= '0;
      addr_q        <= '0;
      page_q        <= '0;
      phys_q        <= '0;
      f_data_q      <= 1'b0;
      f_cause_q     <= '0;
      f_vpn_q       <= '0;
    end else begin
      state_q <= state_d;
      if (grant) begin
        req_is_data_q <= grant_data;
        vpn_q         <= vpn_sel;
        drop_q        <= 1'b0;
        cnt_q         <= '0;
        addr_q        <= bus.ptbr + {{PAD{1'b0}}, vpn_sel, 2'b00};
        if (bus.itlb_miss && bus.dtlb_miss) last_grant_q <= grant_data;
      end
      // The walk runs to completion after a flush so memory is not left with an orphan read.
      if (flush && (state_q == REQ || state_q == WAIT || state_q == FILL || state_q == FAULT))
        drop_q <= 1'b1;
      if (state_q == WAIT) begin
        cnt_q <= cnt_q + 8'd1;
        if (bus.mem_rvalid && bus.mem_rdata[31]) ppn_q <= bus.mem_rdata[PPN_W-1:0];
        if (state_d == FAULT) cause_q <= bus.mem_rvalid ? 2'b01 : 2'b10;
      end
      if (fill_ok) begin
        page_q <= vpn_q;
        phys_q <= ppn_q;
      end
      if (fault_ok) begin
        f_data_q  <= req_is_data_q;
        f_cause_q <= cause_q;
        f_vpn_q   <= vpn_q;
      end
    end
  end

  assign bus.mem_req           = (state_q == REQ);
  assign bus.mem_addr          = addr_q;
  assign bus.busy              = (state_q != IDLE);
  assign bus.itlb_write        = fill_ok & ~req_is_data_q;
  assign bus.dtlb_write        = fill_ok &  req_is_data_q;
  assign bus.tlb_logic_page    = fill_ok ? vpn_q : page_q;
  assign bus.tlb_physical_page = fill_ok ? ppn_q : phys_q;
  assign bus.page_fault        = fault_ok;
  assign bus.fault_is_data     = fault_ok ? req_is_data_q : f_data_q;
  assign bus.fault_cause       = fault_ok ? cause_q       : f_cause_q;
  assign bus.fault_vpn         = fault_ok ? vpn_q         : f_vpn_q;
endmodule

// File: tb/tb_tlb_refill_ctrl.sv
// tb/tb_tlb_refill_ctrl.sv - directed self-checking bench for tlb_refill_ctrl.
module tb_tlb_refill_ctrl;
  logic clk = 1'b0;
  logic reset, flush;
  int   checks = 0;
  int   errors = 0;
  int   cyc;

  always #5 clk = ~clk;

  tlb_refill_ctrl_if #(.VPN_W(20), .PPN_W(8)) bus ();

  tlb_refill_ctrl #(.VPN_W(20), .PPN_W(8), .TIMEOUT(255)) dut (
    .clk   (clk),
    .reset (reset),
    .flush (flush),
    .bus   (bus)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  // Called at a REQ-cycle negedge; returns at the negedge of FILL or FAULT.
  task automatic run_walk(input logic [31:0] pte, input int lat);
    bus.mem_gnt = 1'b1;
    tick();
    bus.mem_gnt = 1'b0;
    repeat (lat - 1) tick();
    bus.mem_rvalid = 1'b1;
    bus.mem_rdata  = pte;
    tick();
    bus.mem_rvalid = 1'b0;
    bus.mem_rdata  = '0;
  endtask

  initial begin
    reset = 1'b1; flush = 1'b0;
    bus.itlb_miss = 1'b0; bus.itlb_vpn = '0;
    bus.dtlb_miss = 1'b0; bus.dtlb_vpn = '0;
    bus.ptbr = '0; bus.mem_gnt = 1'b0; bus.mem_rvalid = 1'b0; bus.mem_rdata = '0;
    tick(); tick();
    reset = 1'b0;
    check("rst_busy", bus.busy, 0);
    check("rst_mem_req", bus.mem_req, 0);
    check("rst_mem_addr", bus.mem_addr, 0);
    check("rst_fault", bus.page_fault, 0);
    check("rst_cause", bus.fault_cause, 0);

    // iTLB fill
    bus.ptbr = 32'h8000; bus.itlb_vpn = 20'h00012; bus.itlb_miss = 1'b1;
    tick();
    check("i_mem_req", bus.mem_req, 1);
    check("i_mem_addr", bus.mem_addr, 32'h8048);
    run_walk(32'h8000_00A5, 3);
    check("i_itlb_write", bus.itlb_write, 1);
    check("i_dtlb_write", bus.dtlb_write, 0);
    check("i_logic_page", bus.tlb_logic_page, 32'h12);
    check("i_phys_page", bus.tlb_physical_page, 32'hA5);
    bus.itlb_miss = 1'b0;
    tick();
    check("i_gap_write", bus.itlb_write, 0);
    check("i_gap_busy", bus.busy, 1);
    check("i_hold_page", bus.tlb_logic_page, 32'h12);
    tick();
    check("i_idle_busy", bus.busy, 0);

    // tie arbitration from reset: i, d, i
    reset = 1'b1; tick(); reset = 1'b0;
    bus.ptbr = '0; bus.itlb_vpn = 20'h100; bus.dtlb_vpn = 20'h200;
    bus.itlb_miss = 1'b1; bus.dtlb_miss = 1'b1;
    tick();
    check("tie1_addr", bus.mem_addr, 32'h400);
    run_walk(32'h8000_0011, 1);
    check("tie1_itlb", bus.itlb_write, 1);
    tick();
    check("tie1_gap_req", bus.mem_req, 0);
    tick();
    check("tie1_idle", bus.busy, 0);
    tick();
    check("tie2_addr", bus.mem_addr, 32'h800);
    run_walk(32'h8000_0022, 2);
    check("tie2_dtlb", bus.dtlb_write, 1);
    check("tie2_itlb", bus.itlb_write, 0);
    check("tie2_phys", bus.tlb_physical_page, 32'h22);
    tick(); tick(); tick();
    check("tie3_addr", bus.mem_addr, 32'h400);
    // misses dropping mid-walk must not cancel the fill
    bus.itlb_miss = 1'b0; bus.dtlb_miss = 1'b0;
    run_walk(32'h8000_0033, 1);
    check("tie3_itlb", bus.itlb_write, 1);
    tick(); tick();

    // invalid PTE with address wrap
    bus.ptbr = 32'hFFC0_0008; bus.dtlb_vpn = 20'hFFFFF; bus.dtlb_miss = 1'b1;
    tick();
    check("inv_addr_wrap", bus.mem_addr, 32'h0000_0004);
    bus.dtlb_miss = 1'b0;
    run_walk(32'h0000_0033, 2);
    check("inv_fault", bus.page_fault, 1);
    check("inv_is_data", bus.fault_is_data, 1);
    check("inv_cause", bus.fault_cause, 2'b01);
    check("inv_vpn", bus.fault_vpn, 32'hFFFFF);
    check("inv_no_write", {bus.itlb_write, bus.dtlb_write}, 0);
    tick();
    check("inv_pulse_end", bus.page_fault, 0);
    check("inv_cause_held", bus.fault_cause, 2'b01);
    tick();

    // timeout
    bus.ptbr = '0; bus.itlb_vpn = 20'h5; bus.itlb_miss = 1'b1;
    tick();
    bus.itlb_miss = 1'b0;
    bus.mem_gnt = 1'b1; tick(); bus.mem_gnt = 1'b0;
    cyc = 0;
    for (int i = 1; i <= 300; i++) begin
      tick();
      if (bus.page_fault) begin
        cyc = i;
        break;
      end
    end
    check("tmo_cycles", cyc, 255);
    check("tmo_cause", bus.fault_cause, 2'b10);
    check("tmo_is_data", bus.fault_is_data, 0);
    check("tmo_vpn", bus.fault_vpn, 32'h5);
    bus.mem_rvalid = 1'b1; bus.mem_rdata = 32'h8000_00FF;
    tick();
    check("tmo_late_write", bus.itlb_write, 0);
    tick();
    bus.mem_rvalid = 1'b0; bus.mem_rdata = '0;
    check("tmo_late_idle", bus.busy, 0);
    check("tmo_phys_held", bus.tlb_physical_page, 32'h33);

    // flush mid-walk
    bus.itlb_vpn = 20'h7; bus.itlb_miss = 1'b1;
    tick();
    bus.itlb_miss = 1'b0;
    bus.mem_gnt = 1'b1; tick(); bus.mem_gnt = 1'b0;
    flush = 1'b1; tick(); flush = 1'b0;
    tick();
    bus.mem_rvalid = 1'b1; bus.mem_rdata = 32'h8000_00C3;
    tick();
    bus.mem_rvalid = 1'b0; bus.mem_rdata = '0;
    check("fl_no_write", {bus.itlb_write, bus.dtlb_write}, 0);
    check("fl_no_fault", bus.page_fault, 0);
    check("fl_phys_held", bus.tlb_physical_page, 32'h33);
    tick();
    check("fl_gap_busy", bus.busy, 1);
    tick();
    check("fl_idle", bus.busy, 0);

    // reset mid-walk
    bus.ptbr = 32'h1000; bus.dtlb_vpn = 20'h9; bus.dtlb_miss = 1'b1;
    tick();
    check("rw_req", bus.mem_req, 1);
    reset = 1'b1;
    tick();
    reset = 1'b0; bus.dtlb_miss = 1'b0;
    check("rw_mem_req", bus.mem_req, 0);
    check("rw_busy", bus.busy, 0);
    check("rw_addr", bus.mem_addr, 0);
    check("rw_fault_regs", {bus.fault_is_data, bus.fault_cause, bus.fault_vpn}, 0);
    check("rw_tlb_regs", {bus.tlb_logic_page, bus.tlb_physical_page}, 0);
    bus.ptbr = '0; bus.itlb_vpn = 20'h1; bus.dtlb_vpn = 20'h2;
    bus.itlb_miss = 1'b1; bus.dtlb_miss = 1'b1;
    tick();
    check("rw_tie_itlb_first", bus.mem_addr, 32'h4);
    reset = 1'b1; tick(); tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
